// File: rtl/bus_ram_slave.sv
// Single-port RAM slave with programmable wait states, B/H/W lane steering and error flagging.
// RAM contents are undefined until written.
module bus_ram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter string       INIT_FILE  = "ram.hex"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_rd,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_wr_data,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_err
);
    localparam int          DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LAT    = 4'(LATENCY);
    localparam logic [32:0] WINDOW = 33'd4 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_bus_en) begin
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are only meaningful once captured, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_bus_en) begin
            wr_q    <= i_wr_rd;
            addr_q  <= i_addr;
            size_q  <= i_size;
            wdata_q <= i_wr_data;
        end
    end

    // ---------------- access checks ----------------
    logic [31:0] off;
    logic        out_win, bad_size, misal, err;

    always_comb begin
        off      = addr_q - BASE_ADDR;
        out_win  = {1'b0, off} >= WINDOW;
        bad_size = (size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111);
        misal    = ((size_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        err      = out_win || bad_size || misal;
    end

    // ---------------- write path ----------------
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic                  we;
    logic [ADDR_WIDTH-1:0] widx;

    always_comb begin
        unique case (size_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_q[1], 1'b0};
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
        widx = addr_q[ADDR_WIDTH+1:2];
        we   = (state_q == S_RESP) && wr_q && !err && !i_rst;
    end

    // NOTE: the RAM array is never reset; clearing it would prevent block-RAM inference.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    // The RAM word is fetched on the edge entering RESP, straight from i_addr when LATENCY=0.
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_en;

    always_comb begin
        rd_idx = (state_q == S_IDLE) ? i_addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
        rd_en  = (state_d == S_RESP);
    end

    always_ff @(posedge i_clk) begin
        if (rd_en) rd_word_q <= mem[rd_idx];
    end

    logic [31:0] shifted, rd_ext;

    always_comb begin
        shifted = rd_word_q >> {addr_q[1:0], 3'b000};
        unique case (size_q)
            3'b000:  rd_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  rd_ext = {24'd0, shifted[7:0]};
            3'b001:  rd_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  rd_ext = {16'd0, shifted[15:0]};
            3'b010:  rd_ext = shifted;
            default: rd_ext = '0;
        endcase
        o_ack     = (state_q == S_RESP);
        o_err     = o_ack && err;
        o_rd_data = (o_ack && !err && !wr_q) ? rd_ext : 32'd0;
    end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Self-checking bench for bus_ram_slave: directed plan items plus random traffic
// against a byte-array reference model; a second instance with LATENCY=0 checks back-to-back.
module tb_bus_ram_slave;
    localparam int          AW   = 12;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] WIN  = 32'd4 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, wr_a, ack_a, err_a;
    logic [31:0] addr_a, wd_a, rd_a;
    logic [2:0]  size_a;
    logic        en_b, wr_b, ack_b, err_b;
    logic [31:0] addr_b, wd_b, rd_b;
    logic [2:0]  size_b;

    bus_ram_slave #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_bus_en(en_a), .i_wr_rd(wr_a), .i_addr(addr_a),
        .i_size(size_a), .i_wr_data(wd_a), .o_ack(ack_a), .o_rd_data(rd_a), .o_err(err_a)
    );

    bus_ram_slave #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .LATENCY(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_bus_en(en_b), .i_wr_rd(wr_b), .i_addr(addr_b),
        .i_size(size_b), .i_wr_data(wd_b), .o_ack(ack_b), .o_rd_data(rd_b), .o_err(err_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model: the first 64 bytes of the window, byte addressed.
    logic [7:0] mem_m [64];

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] off;
        off = a - BASE;
        if (off >= WIN) return 1'b1;
        if (s == 3'b011 || s == 3'b110 || s == 3'b111) return 1'b1;
        if ((s == 3'b001 || s == 3'b101) && (a % 2 != 0)) return 1'b1;
        if (s == 3'b010 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] s);
        int i;
        logic [31:0] v;
        i = int'(a - BASE);
        case (s)
            3'b000:  v = {{24{mem_m[i][7]}}, mem_m[i]};
            3'b100:  v = {24'd0, mem_m[i]};
            3'b001:  v = {{16{mem_m[i+1][7]}}, mem_m[i+1], mem_m[i]};
            3'b101:  v = {16'd0, mem_m[i+1], mem_m[i]};
            default: v = {mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
        endcase
        return v;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int i, n;
        i = int'(a - BASE);
        n = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mem_m[i+k] = d[8*k +: 8];
    endtask

    // One transaction on dut_a; called #1 after a rising edge, returns at the same phase.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
        bit          e_err;
        logic [31:0] e_rd;
        int          cyc;
        bit          seen;
        e_err = m_err(addr, size);
        e_rd  = (e_err || wr) ? 32'd0 : m_read(addr, size);
        en_a = 1'b1; wr_a = wr; addr_a = addr; size_a = size; wd_a = wd;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (ack_a) seen = 1'b1;
        end
        en_a = 1'b0;
        rd   = rd_a;
        err  = err_a;
        check("ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("ack_latency", 32'(cyc), 32'(LAT + 1));
            check("err", 32'(err_a), 32'(e_err));
            if (!wr) check("rd_data", rd_a, e_rd);
        end
        if (wr && !e_err) m_write(addr, size, wd);
        @(posedge clk); #1;
        check("idle_ack", 32'(ack_a), 32'd0);
        check("idle_data", rd_a, 32'd0);
    endtask

    logic [31:0] rd, old;
    logic        er;
    logic [31:0] bd [3];

    initial begin
        rst = 1'b1;
        en_a = 0; wr_a = 0; addr_a = 0; size_a = 0; wd_a = 0;
        en_b = 0; wr_b = 0; addr_b = 0; size_b = 0; wd_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_data_a", rd_a, 32'd0);
        check("rst_ack_b", 32'(ack_b), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Give every modelled word a known value.
        for (int w = 0; w < 16; w++) txn(1'b1, 32'(4 * w), 3'b010, $urandom, rd, er);

        txn(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, rd, er);
        txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er);
        check("dir_w_read", rd, 32'hDEAD_BEEF);
        txn(1'b1, 32'h13, 3'b000, 32'h0000_0080, rd, er);
        txn(1'b0, 32'h13, 3'b000, 32'd0, rd, er);
        check("dir_b_read", rd, 32'hFFFF_FF80);
        txn(1'b0, 32'h13, 3'b100, 32'd0, rd, er);
        check("dir_bu_read", rd, 32'h0000_0080);
        txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er);
        check("dir_w_merge", rd, 32'h80AD_BEEF);
        txn(1'b1, 32'h12, 3'b001, 32'h0000_1234, rd, er);
        txn(1'b0, 32'h12, 3'b101, 32'd0, rd, er);
        check("dir_hu_read", rd, 32'h0000_1234);
        txn(1'b0, 32'h11, 3'b001, 32'd0, rd, er);
        check("dir_h_misal_err", 32'(er), 32'd1);
        check("dir_h_misal_data", rd, 32'd0);
        old = m_read(32'h0, 3'b010);
        txn(1'b1, BASE + 32'h4000, 3'b010, 32'h5555_AAAA, rd, er);
        check("dir_oow_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 3'b010, 32'd0, rd, er);
        check("dir_oow_nowrite", rd, old);
        txn(1'b0, 32'h4, 3'b011, 32'd0, rd, er);
        check("dir_bad_size", 32'(er), 32'd1);

        // Reset during WAIT drops the pending write.
        old = m_read(32'h20, 3'b010);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h20; size_a = 3'b010; wd_a = ~old;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; en_a = 1'b0;
        @(posedge clk); #1;
        check("rstw_ack", 32'(ack_a), 32'd0);
        check("rstw_err", 32'(err_a), 32'd0);
        check("rstw_data", rd_a, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstw_idle", 32'(ack_a), 32'd0);
        txn(1'b0, 32'h20, 3'b010, 32'd0, rd, er);
        check("rstw_old", rd, old);

        // Reset during RESP also drops the write.
        old = m_read(32'h24, 3'b010);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h24; size_a = 3'b010; wd_a = ~old;
        repeat (LAT + 1) @(posedge clk);
        #1;
        check("rstr_ack_before", 32'(ack_a), 32'd1);
        rst = 1'b1; en_a = 1'b0;
        @(posedge clk); #1;
        check("rstr_ack", 32'(ack_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 32'h24, 3'b010, 32'd0, rd, er);
        check("rstr_old", rd, old);

        // Random traffic against the model.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [2:0]  s;
            int          r;
            r = int'($urandom_range(0, 19));
            case (r % 6)
                0: s = 3'b000;
                1: s = 3'b001;
                2: s = 3'b010;
                3: s = 3'b100;
                4: s = 3'b101;
                default: s = 3'(3'b011 + 3'(3 * $urandom_range(0, 1)));
            endcase
            if (r == 0 && s != 3'b011 && s != 3'b110) s = 3'b111;
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? WIN + $urandom_range(0, 255)
                                                 : 32'hFFFF_FF00 + $urandom_range(0, 255);
            else
                a = $urandom_range(0, 63);
            txn($urandom_range(0, 1) == 1, a, s, $urandom, rd, er);
        end

        // LATENCY=0 instance: en held high across six back-to-back requests.
        for (int k = 0; k < 3; k++) bd[k] = $urandom;
        begin
            int k, cyc, since;
            k = 0; cyc = 0; since = 0;
            en_b = 1'b1; wr_b = 1'b1; addr_b = 32'h100; size_b = 3'b010; wd_b = bd[0];
            while (k < 6 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++; since++;
                if (ack_b) begin
                    check("b2b_gap", 32'(since), (k == 0) ? 32'd1 : 32'd2);
                    check("b2b_err", 32'(err_b), 32'd0);
                    if (k >= 3) check("b2b_rd", rd_b, bd[k - 3]);
                    since = 0;
                    k++;
                    if (k < 6) begin
                        wr_b = (k < 3); addr_b = 32'h100 + 32'(4 * (k % 3)); wd_b = bd[k % 3];
                    end else begin
                        en_b = 1'b0;
                    end
                end
            end
            check("b2b_count", 32'(k), 32'd6);
            en_b = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
